atm_session_ctrl: RTL and testbench

//  Session sequencer for the ATM keypad front end. Selects the keypad input mode
//  (input_style), consumes the decoder status/acct/pswd/menu/currency results, and

---
 rtl/atm_session_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// Purpose: ATM keypad session sequencer (input mode select, DB req/ack exchange, PIN lockout, idle timeout).
// Latency: state and all registered outputs update one core edge after the triggering input (done/ack/EXIT).
// Backpressure: db_req is held as a level until db_ack; keypad side has no stall, only edge-detected completion.
module atm_session_ctrl #(
    parameter int TIMEOUT_CYCLES = 300000000,
    parameter int MAX_PIN_TRIES  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  input_status,
    input  logic [15:0] acct_in,
    input  logic [15:0] pswd_in,
    input  logic [1:0]  usr_sel,
    input  logic [2:0]  currency_in,
    input  logic        db_ack,
    input  logic [3:0]  db_result,
    output logic [3:0]  input_style,
    output logic        input_clr,
    output logic        db_req,
    output logic [1:0]  db_op,
    output logic [15:0] db_acct,
    output logic [15:0] db_pin,
    output logic [1:0]  txn_op,
    output logic [2:0]  txn_cur,
    output logic [15:0] cstate,
    output logic [3:0]  status_code,
    output logic        card_lock
);

    // Decoder status codes and database result codes
    localparam logic [3:0] STAT_COMPLETE   = 4'b1000;
    localparam logic [3:0] STAT_EXIT       = 4'b0111;
    localparam logic [3:0] RES_ACC_FOUND   = 4'd1;
    localparam logic [3:0] RES_PIN_CORRECT = 4'd3;

    // Keypad modes
    localparam logic [3:0] STY_NONE   = 4'd0;
    localparam logic [3:0] STY_SINGLE = 4'd1;
    localparam logic [3:0] STY_ACCT   = 4'd2;
    localparam logic [3:0] STY_PIN    = 4'd3;
    localparam logic [3:0] STY_MENU   = 4'd4;
    localparam logic [3:0] STY_CUR    = 4'd5;
    localparam logic [3:0] STY_AMT    = 4'd6;

    // Database operations
    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_PINCHK = 2'd1;
    localparam logic [1:0] OP_EXEC   = 2'd2;

    localparam logic [1:0] USR_BALANCE = 2'd0;

    // Timer only has to reach TIMEOUT_CYCLES-1
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ACCT   = 4'd1,
        S_LOOKUP = 4'd2,
        S_PIN    = 4'd3,
        S_PINCHK = 4'd4,
        S_MENU   = 4'd5,
        S_CUR    = 4'd6,
        S_AMT    = 4'd7,
        S_LOCKED = 4'd8,
        S_EXEC   = 4'd9,
        S_RESULT = 4'd10
    } state_t;

    // States where the keypad is being read (timeout applies, input_clr fires on entry)
    function automatic logic f_is_wait(input state_t s);
        logic v;
        case (s)
            S_ACCT, S_PIN, S_MENU, S_CUR, S_AMT, S_RESULT: v = 1'b1;
            default:                                       v = 1'b0;
        endcase
        return v;
    endfunction

    // States that hold a database request open
    function automatic logic f_is_db(input state_t s);
        logic v;
        case (s)
            S_LOOKUP, S_PINCHK, S_EXEC: v = 1'b1;
            default:                    v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] f_style(input state_t s);
        logic [3:0] v;
        case (s)
            S_ACCT:   v = STY_ACCT;
            S_PIN:    v = STY_PIN;
            S_MENU:   v = STY_MENU;
            S_CUR:    v = STY_CUR;
            S_AMT:    v = STY_AMT;
            S_RESULT: v = STY_SINGLE;
            default:  v = STY_NONE;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] f_op(input state_t s);
        logic [1:0] v;
        case (s)
            S_PINCHK: v = OP_PINCHK;
            S_EXEC:   v = OP_EXEC;
            default:  v = OP_LOOKUP;
        endcase
        return v;
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_prev_status;
    logic [TMR_W-1:0]   r_timer;
    logic [TRY_W-1:0]   r_tries;
    logic [TRY_W-1:0]   w_tries_inc;

    logic [3:0]         r_input_style;
    logic               r_input_clr;
    logic               r_db_req;
    logic [1:0]         r_db_op;
    logic [15:0]        r_db_acct;
    logic [15:0]        r_db_pin;
    logic [1:0]         r_txn_op;
    logic [2:0]         r_txn_cur;
    logic [3:0]         r_status_code;

    logic               w_done;
    logic               w_exit;
    logic               w_ack;
    logic               w_timeout;
    logic               w_fire_timeout;
    logic               w_state_chg;

    // Completion is a rising edge into INPUT_COMPLETE, so a held status acts once
    assign w_done         = (input_status == STAT_COMPLETE) && (r_prev_status != STAT_COMPLETE);
    assign w_exit         = (input_status == STAT_EXIT) && (r_state != S_IDLE) && (r_state != S_LOCKED);
    assign w_ack          = db_ack && f_is_db(r_state);
    assign w_timeout      = f_is_wait(r_state) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_fire_timeout = w_timeout && !w_done && !w_exit;
    assign w_tries_inc    = r_tries + TRY_W'(1);
    assign w_state_chg    = (w_next != r_state);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: EXIT beats done/ack, which beat the idle timeout
    always_comb begin
        w_next = r_state;
        if (w_exit) begin
            w_next = S_IDLE;
        end else if (w_fire_timeout) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_ACCT;
                S_ACCT:   if (w_done) w_next = S_LOOKUP;
                S_LOOKUP: if (w_ack) w_next = (db_result == RES_ACC_FOUND) ? S_PIN : S_ACCT;
                S_PIN:    if (w_done) w_next = S_PINCHK;
                S_PINCHK: begin
                    if (w_ack) begin
                        if (db_result == RES_PIN_CORRECT)
                            w_next = S_MENU;
                        else if (w_tries_inc == TRY_W'(MAX_PIN_TRIES))
                            w_next = S_LOCKED;
                        else
                            w_next = S_PIN;
                    end
                end
                S_MENU:   if (w_done) w_next = (usr_sel == USR_BALANCE) ? S_EXEC : S_CUR;
                S_CUR:    if (w_done) w_next = S_AMT;
                S_AMT:    if (w_done) w_next = S_EXEC;
                S_EXEC:   if (w_ack) w_next = S_RESULT;
                S_RESULT: if (w_done) w_next = S_MENU;
                S_LOCKED: w_next = S_LOCKED;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Registered outputs, latches, retry counter and idle timer, all keyed off the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_status <= 4'd0;
            r_timer       <= '0;
            r_tries       <= '0;
            r_input_style <= STY_NONE;
            r_input_clr   <= 1'b0;
            r_db_req      <= 1'b0;
            r_db_op       <= 2'd0;
            r_db_acct     <= 16'd0;
            r_db_pin      <= 16'd0;
            r_txn_op      <= 2'd0;
            r_txn_cur     <= 3'd0;
            r_status_code <= 4'd0;
        end else begin
            r_prev_status <= input_status;
            r_input_style <= f_style(w_next);
            r_input_clr   <= w_state_chg && f_is_wait(w_next);
            // Request is high from the first DB-state cycle through the ack cycle
            r_db_req      <= f_is_db(w_next);
            if (f_is_db(w_next))
                r_db_op <= f_op(w_next);

            if (r_state == S_ACCT && w_next == S_LOOKUP)
                r_db_acct <= acct_in;
            if (r_state == S_PIN && w_next == S_PINCHK)
                r_db_pin <= pswd_in;
            if (r_state == S_MENU && (w_next == S_CUR || w_next == S_EXEC))
                r_txn_op <= usr_sel;
            if (r_state == S_CUR && w_next == S_AMT)
                r_txn_cur <= currency_in;

            if (w_exit || w_fire_timeout)
                r_status_code <= STAT_EXIT;
            else if (w_ack)
                r_status_code <= db_result;

            // A new card starts with a clean retry count
            if (w_exit || (r_state == S_IDLE && start))
                r_tries <= '0;
            else if (r_state == S_PINCHK && w_ack)
                r_tries <= (db_result == RES_PIN_CORRECT) ? '0 : w_tries_inc;

            if (w_state_chg || w_done)
                r_timer <= '0;
            else if (f_is_wait(r_state))
                r_timer <= r_timer + TMR_W'(1);
            else
                r_timer <= '0;
        end
    end

    // Output drive: state-derived outputs plus the registered set
    always_comb begin
        cstate      = {12'd0, r_state};
        card_lock   = (r_state == S_LOCKED);
        input_style = r_input_style;
        input_clr   = r_input_clr;
        db_req      = r_db_req;
        db_op       = r_db_op;
        db_acct     = r_db_acct;
        db_pin      = r_db_pin;
        txn_op      = r_txn_op;
        txn_cur     = r_txn_cur;
        status_code = r_status_code;
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a short idle timeout.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Each scenario task carries its own inline comparisons.
module tb_atm_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  input_status;
    logic [15:0] acct_in;
    logic [15:0] pswd_in;
    logic [1:0]  usr_sel;
    logic [2:0]  currency_in;
    logic        db_ack;
    logic [3:0]  db_result;
    logic [3:0]  input_style;
    logic        input_clr;
    logic        db_req;
    logic [1:0]  db_op;
    logic [15:0] db_acct;
    logic [15:0] db_pin;
    logic [1:0]  txn_op;
    logic [2:0]  txn_cur;
    logic [15:0] cstate;
    logic [3:0]  status_code;
    logic        card_lock;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    atm_session_ctrl #(.TIMEOUT_CYCLES(16), .MAX_PIN_TRIES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .input_status(input_status),
        .acct_in(acct_in), .pswd_in(pswd_in), .usr_sel(usr_sel), .currency_in(currency_in),
        .db_ack(db_ack), .db_result(db_result), .input_style(input_style), .input_clr(input_clr),
        .db_req(db_req), .db_op(db_op), .db_acct(db_acct), .db_pin(db_pin), .txn_op(txn_op),
        .txn_cur(txn_cur), .cstate(cstate), .status_code(status_code), .card_lock(card_lock)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One idle cycle so the next INPUT_COMPLETE is a fresh edge, then a one-cycle completion
    task automatic do_done();
        input_status = 4'h0;
        step();
        input_status = 4'h8;
        step();
        input_status = 4'h0;
    endtask

    task automatic do_ack(input logic [3:0] res);
        db_ack    = 1'b1;
        db_result = res;
        step();
        db_ack    = 1'b0;
        db_result = 4'h0;
    endtask

    task automatic go_menu();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        acct_in = 16'h1234;
        do_done();
        do_ack(4'd1);
        pswd_in = 16'h4321;
        do_done();
        do_ack(4'd3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cstate !== 16'd0) begin errors++; $display("FAIL reset_cstate got %0d exp 0", cstate); end
        checks++; if (input_style !== 4'd0) begin errors++; $display("FAIL reset_style got %0d exp 0", input_style); end
        checks++; if (db_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", db_req); end
        checks++; if (status_code !== 4'd0) begin errors++; $display("FAIL reset_status got %0d exp 0", status_code); end
        checks++; if (card_lock !== 1'b0 || input_clr !== 1'b0) begin errors++; $display("FAIL reset_lock_clr got %b%b exp 00", card_lock, input_clr); end
    endtask

    task automatic test_login();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (cstate !== 16'd1) begin errors++; $display("FAIL login_acct_state got %0d exp 1", cstate); end
        checks++; if (input_style !== 4'd2) begin errors++; $display("FAIL login_acct_style got %0d exp 2", input_style); end
        checks++; if (input_clr !== 1'b1) begin errors++; $display("FAIL login_acct_clr got %b exp 1", input_clr); end
        step();
        checks++; if (input_clr !== 1'b0) begin errors++; $display("FAIL login_clr_pulse got %b exp 0", input_clr); end
        acct_in = 16'h1234;
        do_done();
        checks++; if (cstate !== 16'd2) begin errors++; $display("FAIL login_lookup_state got %0d exp 2", cstate); end
        checks++; if (db_req !== 1'b1 || db_op !== 2'd0) begin errors++; $display("FAIL login_lookup_req got req=%b op=%0d exp req=1 op=0", db_req, db_op); end
        checks++; if (db_acct !== 16'h1234) begin errors++; $display("FAIL login_acct_latch got %h exp 1234", db_acct); end
        // Account not found goes back for re-entry
        do_ack(4'd2);
        checks++; if (cstate !== 16'd1 || input_clr !== 1'b1) begin errors++; $display("FAIL login_notfound got state=%0d clr=%b exp state=1 clr=1", cstate, input_clr); end
        checks++; if (status_code !== 4'd2 || db_req !== 1'b0) begin errors++; $display("FAIL login_notfound_status got st=%0d req=%b exp st=2 req=0", status_code, db_req); end
        do_done();
        step();
        checks++; if (db_req !== 1'b1) begin errors++; $display("FAIL login_req_hold got %b exp 1", db_req); end
        do_ack(4'd1);
        checks++; if (cstate !== 16'd3 || input_style !== 4'd3) begin errors++; $display("FAIL login_pin got state=%0d style=%0d exp 3/3", cstate, input_style); end
        checks++; if (db_req !== 1'b0 || status_code !== 4'd1) begin errors++; $display("FAIL login_after_ack got req=%b st=%0d exp req=0 st=1", db_req, status_code); end
        pswd_in = 16'h5678;
        do_done();
        checks++; if (cstate !== 16'd4 || db_op !== 2'd1 || db_req !== 1'b1) begin errors++; $display("FAIL login_pinchk got state=%0d op=%0d req=%b exp 4/1/1", cstate, db_op, db_req); end
        checks++; if (db_pin !== 16'h5678) begin errors++; $display("FAIL login_pin_latch got %h exp 5678", db_pin); end
        do_ack(4'd3);
        checks++; if (cstate !== 16'd5 || input_style !== 4'd4 || status_code !== 4'd3) begin errors++; $display("FAIL login_menu got state=%0d style=%0d st=%0d exp 5/4/3", cstate, input_style, status_code); end
    endtask

    task automatic test_lockout();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        do_done();
        do_ack(4'd1);
        for (int i = 0; i < 3; i++) begin
            do_done();
            checks++; if (cstate !== 16'd4) begin errors++; $display("FAIL lock_pinchk_%0d got %0d exp 4", i, cstate); end
            do_ack(4'd4);
            checks++; if (cstate !== ((i < 2) ? 16'd3 : 16'd8)) begin errors++; $display("FAIL lock_after_ack_%0d got %0d exp %0d", i, cstate, (i < 2) ? 3 : 8); end
        end
        checks++; if (card_lock !== 1'b1 || input_style !== 4'd0 || db_req !== 1'b0) begin errors++; $display("FAIL lock_outputs got lock=%b style=%0d req=%b exp 1/0/0", card_lock, input_style, db_req); end
        start = 1'b1;
        step();
        start = 1'b0;
        input_status = 4'h7;
        step();
        input_status = 4'h0;
        checks++; if (cstate !== 16'd8) begin errors++; $display("FAIL lock_sticky got %0d exp 8", cstate); end
        do_reset();
        checks++; if (cstate !== 16'd0 || card_lock !== 1'b0) begin errors++; $display("FAIL lock_reset got state=%0d lock=%b exp 0/0", cstate, card_lock); end
    endtask

    task automatic test_txn();
        go_menu();
        // Ack outside a DB state must be ignored
        do_ack(4'd9);
        checks++; if (cstate !== 16'd5 || status_code !== 4'd3) begin errors++; $display("FAIL txn_stray_ack got state=%0d st=%0d exp 5/3", cstate, status_code); end
        usr_sel = 2'd2;
        do_done();
        checks++; if (cstate !== 16'd6 || txn_op !== 2'd2 || input_style !== 4'd5) begin errors++; $display("FAIL txn_cur got state=%0d op=%0d style=%0d exp 6/2/5", cstate, txn_op, input_style); end
        currency_in = 3'b001;
        do_done();
        checks++; if (cstate !== 16'd7 || txn_cur !== 3'd1 || input_style !== 4'd6) begin errors++; $display("FAIL txn_amt got state=%0d cur=%0d style=%0d exp 7/1/6", cstate, txn_cur, input_style); end
        do_done();
        checks++; if (cstate !== 16'd9 || db_req !== 1'b1 || db_op !== 2'd2) begin errors++; $display("FAIL txn_exec got state=%0d req=%b op=%0d exp 9/1/2", cstate, db_req, db_op); end
        do_ack(4'd5);
        checks++; if (cstate !== 16'd10 || status_code !== 4'd5 || input_style !== 4'd1 || db_req !== 1'b0) begin errors++; $display("FAIL txn_result got state=%0d st=%0d style=%0d req=%b exp 10/5/1/0", cstate, status_code, input_style, db_req); end
        do_done();
        checks++; if (cstate !== 16'd5) begin errors++; $display("FAIL txn_back_menu got %0d exp 5", cstate); end
        usr_sel = 2'd0;
        do_done();
        checks++; if (cstate !== 16'd9 || txn_op !== 2'd0) begin errors++; $display("FAIL txn_balance got state=%0d op=%0d exp 9/0", cstate, txn_op); end
    endtask

    task automatic test_exit();
        go_menu();
        usr_sel = 2'd2;
        do_done();
        do_done();
        checks++; if (cstate !== 16'd7) begin errors++; $display("FAIL exit_setup got %0d exp 7", cstate); end
        input_status = 4'h7;
        step();
        input_status = 4'h0;
        checks++; if (cstate !== 16'd0 || status_code !== 4'd7 || db_req !== 1'b0) begin errors++; $display("FAIL exit_amt got state=%0d st=%0d req=%b exp 0/7/0", cstate, status_code, db_req); end
        // EXIT coinciding with an ack while a request is open
        go_menu();
        usr_sel = 2'd0;
        do_done();
        input_status = 4'h7;
        db_ack = 1'b1;
        db_result = 4'd5;
        step();
        input_status = 4'h0;
        db_ack = 1'b0;
        db_result = 4'd0;
        checks++; if (cstate !== 16'd0 || status_code !== 4'd7 || db_req !== 1'b0) begin errors++; $display("FAIL exit_vs_ack got state=%0d st=%0d req=%b exp 0/7/0", cstate, status_code, db_req); end
    endtask

    task automatic test_timeout();
        go_menu();
        for (int i = 0; i < 15; i++) step();
        checks++; if (cstate !== 16'd5) begin errors++; $display("FAIL tmo_before got %0d exp 5", cstate); end
        step();
        checks++; if (cstate !== 16'd0 || status_code !== 4'd7) begin errors++; $display("FAIL tmo_fire got state=%0d st=%0d exp 0/7", cstate, status_code); end
        // Completion mid-count restarts the timer in the new state
        go_menu();
        for (int i = 0; i < 9; i++) step();
        usr_sel = 2'd1;
        do_done();
        for (int i = 0; i < 15; i++) step();
        checks++; if (cstate !== 16'd6) begin errors++; $display("FAIL tmo_restart_hold got %0d exp 6", cstate); end
        step();
        checks++; if (cstate !== 16'd0) begin errors++; $display("FAIL tmo_restart_fire got %0d exp 0", cstate); end
        // No timeout while waiting on the database
        start = 1'b1;
        step();
        start = 1'b0;
        do_done();
        for (int i = 0; i < 40; i++) step();
        checks++; if (cstate !== 16'd2 || db_req !== 1'b1) begin errors++; $display("FAIL tmo_db_wait got state=%0d req=%b exp 2/1", cstate, db_req); end
    endtask

    task automatic test_held_status();
        go_menu();
        usr_sel = 2'd0;
        do_done();
        do_ack(4'd6);
        checks++; if (cstate !== 16'd10) begin errors++; $display("FAIL held_setup got %0d exp 10", cstate); end
        usr_sel = 2'd2;
        input_status = 4'h8;
        for (int i = 0; i < 5; i++) step();
        input_status = 4'h0;
        checks++; if (cstate !== 16'd5) begin errors++; $display("FAIL held_one_transition got %0d exp 5", cstate); end
    endtask

    task automatic test_rst_lookup();
        input_status = 4'h7;
        step();
        input_status = 4'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        acct_in = 16'h9999;
        do_done();
        checks++; if (cstate !== 16'd2 || db_req !== 1'b1 || db_acct !== 16'h9999) begin errors++; $display("FAIL rst_setup got state=%0d req=%b acct=%h exp 2/1/9999", cstate, db_req, db_acct); end
        rst = 1'b1;
        step();
        checks++; if (cstate !== 16'd0 || db_req !== 1'b0 || db_acct !== 16'd0 || db_pin !== 16'd0) begin errors++; $display("FAIL rst_lookup_a got state=%0d req=%b acct=%h pin=%h exp all 0", cstate, db_req, db_acct, db_pin); end
        checks++; if (status_code !== 4'd0 || input_style !== 4'd0 || db_op !== 2'd0 || txn_op !== 2'd0 || txn_cur !== 3'd0 || input_clr !== 1'b0 || card_lock !== 1'b0) begin errors++; $display("FAIL rst_lookup_b got st=%0d sty=%0d op=%0d top=%0d cur=%0d clr=%b lock=%b exp all 0", status_code, input_style, db_op, txn_op, txn_cur, input_clr, card_lock); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; input_status = 4'h0; acct_in = 16'h0; pswd_in = 16'h0;
        usr_sel = 2'd0; currency_in = 3'd0; db_ack = 1'b0; db_result = 4'd0;
        test_reset();
        test_login();
        test_lockout();
        test_txn();
        test_exit();
        test_timeout();
        test_held_status();
        test_rst_lookup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
